// File: rtl/seg7_pkg.sv
// Shared seven-segment tables: active-low segment patterns, anode codes and digit helpers.
// Both the display encoder and the scan decoder import this package, so the two ends use one table.
package seg7_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_A     = 8'h88;
   localparam logic [7:0] SEG_B     = 8'h83;
   localparam logic [7:0] SEG_C     = 8'hC6;
   localparam logic [7:0] SEG_D     = 8'hA1;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] ANO_D0 = 4'b1110;
   localparam logic [3:0] ANO_D1 = 4'b1101;
   localparam logic [3:0] ANO_D2 = 4'b1011;
   localparam logic [3:0] ANO_D3 = 4'b0111;

   typedef logic [1:0] digit_t;

   // READY means the sampled bus has been stable long enough and not yet captured.
   typedef enum logic {SETTLING, READY} scan_state_t;

   function automatic logic ano_legal(input logic [3:0] ano);
      return (ano == ANO_D0) || (ano == ANO_D1) || (ano == ANO_D2) || (ano == ANO_D3);
   endfunction

   function automatic digit_t ano_digit(input logic [3:0] ano);
      digit_t d;
      d = 2'd0;
      case (ano)
         ANO_D1:  d = 2'd1;
         ANO_D2:  d = 2'd2;
         ANO_D3:  d = 2'd3;
         default: d = 2'd0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup: active-low segment pattern to hex nibble.
// Blank decodes to F; any unknown pattern yields nibble 0 with invalid set.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [7:0] seg,
   output logic [3:0] nibble,
   output logic       invalid
);

   always_comb begin
      nibble  = 4'h0;
      invalid = 1'b0;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_BLANK: nibble = 4'hF;
         default: begin
            nibble  = 4'h0;
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 4-digit display bus, captures each digit once it settles,
// and assembles the four decoded nibbles into a 16-bit frame.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg_in,
   input  logic [3:0]  ano_in,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        pat_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [7:0]       r_seg;
   logic [3:0]       r_ano;
   logic [CNT_W-1:0] cnt_reg;
   logic             taken_reg;
   logic [3:0]       seen_reg;
   logic [3:0]       bad_reg;
   logic [15:0]      shadow_reg;

   scan_state_t state;
   logic        cap;
   digit_t      dig;
   logic [3:0]  nibble;
   logic        invalid;
   logic [3:0]  sel;
   logic [3:0]  seen_upd;
   logic [3:0]  bad_upd;
   logic [15:0] merged;
   logic        frame_done;

   seg7_pattern_decode u_decode (
      .seg     (r_seg),
      .nibble  (nibble),
      .invalid (invalid)
   );

   always_comb begin
      state = SETTLING;
      if ((cnt_reg == CNT_MAX) && !taken_reg) begin
         state = READY;
      end
      cap = (state == READY) && ano_legal(r_ano);
      dig = ano_digit(r_ano);
   end

   // Per-digit view of the frame as it would look after this edge's capture.
   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign sel[gi]             = cap && (dig == digit_t'(gi));
      assign seen_upd[gi]        = seen_reg[gi] | sel[gi];
      assign bad_upd[gi]         = sel[gi] ? invalid : bad_reg[gi];
      assign merged[gi*4 +: 4]   = sel[gi] ? nibble : shadow_reg[gi*4 +: 4];
   end

   assign frame_done = cap && (seen_upd == 4'hF);

   // Any change on the bus restarts the settle window and re-arms capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg     <= 8'hFF;
         r_ano     <= 4'hF;
         cnt_reg   <= '0;
         taken_reg <= 1'b0;
      end else if ({seg_in, ano_in} != {r_seg, r_ano}) begin
         r_seg     <= seg_in;
         r_ano     <= ano_in;
         cnt_reg   <= '0;
         taken_reg <= 1'b0;
      end else begin
         if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (cap) begin
            taken_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         pat_err     <= 1'b0;
         seen_reg    <= '0;
         bad_reg     <= '0;
         shadow_reg  <= '0;
      end else begin
         pat_err     <= cap && invalid;
         frame_valid <= frame_done;
         if (frame_done) begin
            value     <= merged;
            frame_err <= |bad_upd;
            seen_reg  <= '0;
            bad_reg   <= '0;
         end else if (cap) begin
            shadow_reg <= merged;
            seen_reg   <= seen_upd;
            bad_reg    <= bad_upd;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench: expected frames are queued as stimulus is issued; a negedge monitor
// pops and compares whenever frame_valid pulses.
module tb_seg7_scan_decoder;

   logic        clk;
   logic        rst_n;
   logic [7:0]  seg_in;
   logic [3:0]  ano_in;
   logic [15:0] value;
   logic        frame_valid;
   logic        frame_err;
   logic        pat_err;

   typedef struct {
      logic [15:0] v;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_bad;
   int   n_frm;
   int   n_pat;

   seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .ano_in      (ano_in),
      .value       (value),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .pat_err     (pat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic send(input logic [3:0] a, input logic [7:0] s, input int cycles);
      ano_in = a;
      seg_in = s;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v, input logic e);
      exp_t x;
      x.v = v;
      x.e = e;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (rst_n && pat_err) begin
         n_pat++;
         $display("pat_err pulse #%0d", n_pat);
      end
      if (rst_n && frame_valid) begin
         n_frm++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got value %h err %b, none expected", value, frame_err);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            check("frame_value", 32'(value), 32'(x.v));
            check("frame_err", 32'(frame_err), 32'(x.e));
         end
      end
   end

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      n_frm  = 0;
      n_pat  = 0;
      rst_n  = 1'b0;
      seg_in = 8'hFF;
      ano_in = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      check("rst_value", 32'(value), 32'h0);
      check("rst_frame_valid", 32'(frame_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_pat_err", 32'(pat_err), 32'h0);
      rst_n = 1'b1;

      // Plain frame 3210.
      push(16'h3210, 1'b0);
      send(4'b1110, 8'hC0, 6);
      send(4'b1101, 8'hF9, 6);
      send(4'b1011, 8'hA4, 6);
      send(4'b0111, 8'hB0, 6);
      send(4'hF, 8'hFF, 3);
      check("t1_frames", 32'(n_frm), 32'd1);
      check("t1_pat", 32'(n_pat), 32'd0);

      // Digit 0 held too briefly: digits 1..3 alone must not complete a frame.
      send(4'b1110, 8'hC0, 3);
      send(4'b1101, 8'h99, 6);
      send(4'b1011, 8'h92, 6);
      send(4'b0111, 8'h82, 6);
      send(4'hF, 8'hFF, 3);
      check("t2_no_frame", 32'(n_frm), 32'd1);
      check("t2_value_held", 32'(value), 32'h3210);
      push(16'h6548, 1'b0);
      send(4'b1110, 8'h80, 6);
      send(4'hF, 8'hFF, 3);
      check("t2_frames", 32'(n_frm), 32'd2);

      // Blank digit 2 and invalid digit 1.
      push(16'hBF0A, 1'b1);
      send(4'b1110, 8'h88, 6);
      send(4'b1101, 8'h7F, 6);
      send(4'b1011, 8'hFF, 6);
      send(4'b0111, 8'h83, 6);
      send(4'hF, 8'hFF, 3);
      check("t3_frames", 32'(n_frm), 32'd3);
      check("t3_pat", 32'(n_pat), 32'd1);

      // Digit 0 recaptured before the frame completes.
      push(16'h9DCE, 1'b0);
      send(4'b1110, 8'hC0, 6);
      send(4'b1110, 8'h86, 6);
      send(4'b1101, 8'hC6, 6);
      send(4'b1011, 8'hA1, 6);
      send(4'b0111, 8'h90, 6);
      send(4'hF, 8'hFF, 3);
      check("t4_frames", 32'(n_frm), 32'd4);

      // Illegal anode codes never capture, even with an invalid pattern present.
      send(4'b1111, 8'h7F, 20);
      send(4'b1100, 8'h7F, 20);
      send(4'hF, 8'hFF, 3);
      check("t5_frames", 32'(n_frm), 32'd4);
      check("t5_pat", 32'(n_pat), 32'd1);
      check("t5_value_held", 32'(value), 32'h9DCE);

      // Reset mid-frame after three digits.
      send(4'b1110, 8'hF9, 6);
      send(4'b1101, 8'hA4, 6);
      send(4'b1011, 8'hB0, 6);
      send(4'hF, 8'hFF, 2);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_value", 32'(value), 32'h0);
      check("t6_rst_frame_valid", 32'(frame_valid), 32'h0);
      check("t6_rst_frame_err", 32'(frame_err), 32'h0);
      check("t6_rst_pat_err", 32'(pat_err), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push(16'h8765, 1'b0);
      send(4'b1110, 8'h92, 6);
      send(4'b1101, 8'h82, 6);
      send(4'b1011, 8'hF8, 6);
      send(4'b0111, 8'h80, 6);
      send(4'hF, 8'hFF, 3);
      check("t6_frames", 32'(n_frm), 32'd5);
      check("t6_pat", 32'(n_pat), 32'd1);

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
